// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-word bit map and NOP encoding.
package pipe_pkg;

  localparam int CTRL_W        = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice with an optional second (skid) entry and synchronous flush.
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         head_vld_q, head_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         accept, drain;

  generate
    if (SKID_EN) begin : g_skid
      // Registered ready: no combinational path from out_ready_i.
      assign in_ready_o = ~skid_vld_q;
    end else begin : g_noskid
      assign in_ready_o = ~head_vld_q | out_ready_i;
    end
  endgenerate

  assign accept = in_valid_i & in_ready_o;
  assign drain  = head_vld_q & out_ready_i;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!head_vld_q || drain) begin
      // The skid entry is older than anything on the input, so it goes first.
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        head_d     = in_data_i;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (accept && SKID_EN) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid_o = head_vld_q;
  assign out_data_o  = head_q;
  assign occ_o       = {1'b0, head_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register: packs decode outputs into one payload and passes it through a skid slice.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = pipe_pkg::CTRL_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               bubble_in,
  input  logic               flush_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [DATA_W-1:0]  rd1_in,
  input  logic [DATA_W-1:0]  rd2_in,
  input  logic [DATA_W-1:0]  imm_in,
  input  logic [RADDR_W-1:0] rs_in,
  input  logic [RADDR_W-1:0] rt_in,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [DATA_W-1:0]  rd1_out,
  output logic [DATA_W-1:0]  rd2_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic [RADDR_W-1:0] rs_out,
  output logic [RADDR_W-1:0] rt_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic [1:0]         occ
);

  localparam int PAY_W = CTRL_W + 3 * DATA_W + 3 * RADDR_W;

  logic [CTRL_W-1:0] ctrl_masked;
  logic [CTRL_W-1:0] ctrl_head;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;

  // A load-use bubble still occupies a slot; only its control word is neutralised.
  assign ctrl_masked = bubble_in ? CTRL_W'(CTRL_NOP) : ctrl_in;
  assign pay_in      = {ctrl_masked, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};

  pipe_skid_buf #(
    .W       (PAY_W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk         (clk),
    .rst_n       (reset_in),
    .flush_i     (flush_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (pay_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (pay_out),
    .occ_o       (occ)
  );

  assign {ctrl_head, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} = pay_out;

  // Downstream decodes ctrl without qualifying by valid, so an empty head must read as NOP.
  assign ctrl_out = out_valid ? ctrl_head : CTRL_W'(CTRL_NOP);

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed bench for id_ex_pipe_stage; a second instance with SKID_EN=0 shares the stimulus.
module tb_id_ex_pipe_stage;

  logic        clk = 1'b0;
  logic        reset_in, in_valid, bubble_in, flush_in, out_ready;
  logic [7:0]  ctrl_in;
  logic [31:0] rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic        in_ready, out_valid;
  logic [7:0]  ctrl_out;
  logic [31:0] rd1_out, rd2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [1:0]  occ;

  logic        s0_in_ready, s0_out_valid;
  logic [7:0]  s0_ctrl_out;
  logic [31:0] s0_rd1_out, s0_rd2_out, s0_imm_out;
  logic [4:0]  s0_rs_out, s0_rt_out, s0_rd_out;
  logic [1:0]  s0_occ;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.DATA_W(32), .RADDR_W(5), .CTRL_W(8), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset_in(reset_in), .in_valid(in_valid), .in_ready(in_ready),
    .bubble_in(bubble_in), .flush_in(flush_in), .ctrl_in(ctrl_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .occ(occ)
  );

  id_ex_pipe_stage #(.DATA_W(32), .RADDR_W(5), .CTRL_W(8), .SKID_EN(1'b0)) dut_s0 (
    .clk(clk), .reset_in(reset_in), .in_valid(in_valid), .in_ready(s0_in_ready),
    .bubble_in(bubble_in), .flush_in(flush_in), .ctrl_in(ctrl_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .out_valid(s0_out_valid), .out_ready(out_ready), .ctrl_out(s0_ctrl_out),
    .rd1_out(s0_rd1_out), .rd2_out(s0_rd2_out), .imm_out(s0_imm_out),
    .rs_out(s0_rs_out), .rt_out(s0_rt_out), .rd_out(s0_rd_out), .occ(s0_occ)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] c, input logic [31:0] d);
    in_valid = 1'b1;
    ctrl_in  = c;
    rd1_in   = d;
    rd2_in   = ~d;
    imm_in   = d + 32'd1;
    rs_in    = d[4:0];
    rt_in    = d[4:0] + 5'd1;
    rd_in    = d[4:0] + 5'd2;
  endtask

  task automatic test_reset();
    reset_in = 1'b0; in_valid = 1'b0; bubble_in = 1'b0; flush_in = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; rd1_in = '0; rd2_in = '0; imm_in = '0; rs_in = '0; rt_in = '0; rd_in = '0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl got=%h want=00", ctrl_out); end
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
    n_cmp++; if (rd1_out !== 32'h0) begin n_bad++; $display("FAIL reset_rd1 got=%h want=0", rd1_out); end
    reset_in = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (s0_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s0_in_ready got=%b want=1", s0_in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    offer(8'h31, 32'h0000_0005);
    rs_in = 5'd3;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    n_cmp++; if (ctrl_out !== 8'h31) begin n_bad++; $display("FAIL single_ctrl got=%h want=31", ctrl_out); end
    n_cmp++; if (rd1_out !== 32'h5) begin n_bad++; $display("FAIL single_rd1 got=%h want=5", rd1_out); end
    n_cmp++; if (rs_out !== 5'd3) begin n_bad++; $display("FAIL single_rs got=%0d want=3", rs_out); end
    n_cmp++; if (imm_out !== 32'h6) begin n_bad++; $display("FAIL single_imm got=%h want=6", imm_out); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty_valid got=%b want=0", out_valid); end
    n_cmp++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL single_empty_ctrl got=%h want=00", ctrl_out); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(8'h11, 32'hAAAA_0001);
    step();
    n_cmp++; if (occ !== 2'd1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_first occ=%0d rdy=%b want occ=1 rdy=1", occ, in_ready); end
    offer(8'h22, 32'hBBBB_0002);
    step();
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL bp_full_occ got=%0d want=2", occ); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
    n_cmp++; if (ctrl_out !== 8'h11 || rd1_out !== 32'hAAAA_0001) begin n_bad++; $display("FAIL bp_head_a ctrl=%h rd1=%h want 11/aaaa0001", ctrl_out, rd1_out); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (ctrl_out !== 8'h22 || rd1_out !== 32'hBBBB_0002 || rd2_out !== 32'h4444_FFFD) begin n_bad++; $display("FAIL bp_head_b ctrl=%h rd1=%h rd2=%h want 22/bbbb0002/4444fffd", ctrl_out, rd1_out, rd2_out); end
    n_cmp++; if (occ !== 2'd1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_a occ=%0d rdy=%b want occ=1 rdy=1", occ, in_ready); end
    step();
    n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained occ=%0d vld=%b want 0/0", occ, out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    offer(8'hFF, 32'h0000_0077);
    bubble_in = 1'b1;
    step();
    in_valid = 1'b0; bubble_in = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bubble_valid got=%b want=1", out_valid); end
    n_cmp++; if (ctrl_out !== 8'h00) begin n_bad++; $display("FAIL bubble_ctrl got=%h want=00", ctrl_out); end
    n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL bubble_occ got=%0d want=1", occ); end
    step();
    n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL bubble_drain_occ got=%0d want=0", occ); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(8'h41, 32'h41); step();
    offer(8'h42, 32'h42); step();
    n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL flush_fill_occ got=%0d want=2", occ); end
    offer(8'h43, 32'h43);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0 || ctrl_out !== 8'h00) begin n_bad++; $display("FAIL flush_full occ=%0d vld=%b ctrl=%h want 0/0/00", occ, out_valid, ctrl_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_ghost got=%b ctrl=%h want vld=0", out_valid, ctrl_out); end
    // Flush while one entry is held and an accept would otherwise succeed.
    out_ready = 1'b0;
    offer(8'h51, 32'h51); step();
    offer(8'h52, 32'h52);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept occ=%0d vld=%b want 0/0", occ, out_valid); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_ghost got=%b ctrl=%h want vld=0", out_valid, ctrl_out); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    offer(8'h61, 32'h61); step();
    offer(8'h62, 32'h62); step();
    in_valid = 1'b0;
    n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL areset_fill_occ got=%0d want=2", occ); end
    #2;
    reset_in = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || ctrl_out !== 8'h00) begin n_bad++; $display("FAIL areset_out vld=%b ctrl=%h want 0/00", out_valid, ctrl_out); end
    n_cmp++; if (occ !== 2'd0 || s0_occ !== 2'd0) begin n_bad++; $display("FAIL areset_occ occ=%0d s0_occ=%0d want 0/0", occ, s0_occ); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready got=%b want=1", in_ready); end
    #2;
    reset_in = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_replay got=%b ctrl=%h want vld=0", out_valid, ctrl_out); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] q1[$];
    logic [39:0] q0[$];
    logic [39:0] exp;
    int sent = 0;
    int cyc  = 0;
    out_ready = 1'b1;
    while ((sent < 100 || q1.size() != 0 || q0.size() != 0) && cyc < 1000) begin
      in_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      ctrl_in  = 8'(sent + 1);
      rd1_in   = 32'(sent * 7 + 3);
      #1;
      if (in_valid && in_ready)    q1.push_back({ctrl_in, rd1_in});
      if (in_valid && s0_in_ready) q0.push_back({ctrl_in, rd1_in});
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
      if (out_valid) begin
        n_cmp++;
        if (q1.size() == 0) begin n_bad++; $display("FAIL stream_skid_extra ctrl=%h want none", ctrl_out); end
        else begin
          exp = q1.pop_front();
          if ({ctrl_out, rd1_out} !== exp) begin n_bad++; $display("FAIL stream_skid got=%h want=%h", {ctrl_out, rd1_out}, exp); end
        end
      end
      if (s0_out_valid) begin
        n_cmp++;
        if (q0.size() == 0) begin n_bad++; $display("FAIL stream_noskid_extra ctrl=%h want none", s0_ctrl_out); end
        else begin
          exp = q0.pop_front();
          if ({s0_ctrl_out, s0_rd1_out} !== exp) begin n_bad++; $display("FAIL stream_noskid got=%h want=%h", {s0_ctrl_out, s0_rd1_out}, exp); end
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (cyc >= 1000) begin n_bad++; $display("FAIL stream_timeout sent=%0d want=100", sent); end
    n_cmp++; if (q1.size() != 0 || q0.size() != 0) begin n_bad++; $display("FAIL stream_lost skid_left=%0d noskid_left=%0d want 0/0", q1.size(), q0.size()); end
    step();
    n_cmp++; if (occ !== 2'd0 || s0_occ !== 2'd0) begin n_bad++; $display("FAIL stream_end_occ occ=%0d s0_occ=%0d want 0/0", occ, s0_occ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Carries the decoded control word, two register-read operands, the sign-extended immediate, and the Rs/Rt/Rd addresses.
- Supports back-pressure from EX (multi-cycle ALU ops), bubble insertion from the hazard unit (load-use), and flush from branch resolution.
- Sits between decode/register file and the EX stage, forwarding unit and destination-register mux.

Parameters:
- DATA_W, 32, width of operand and immediate fields.
- RADDR_W, 5, register address width.
- CTRL_W, 8, control word width; bit map is defined in pipe_pkg.
- SKID_EN, 1, 1 selects the 2-entry skid buffer; 0 selects a single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset_in  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- bubble_in  in  1  hazard unit: accept the transfer as a NOP.
- flush_in  in  1  kill all held entries.
- ctrl_in  in  CTRL_W  control word: RegWrite, MemtoReg, MemRead, MemWrite, RegDst, ALU_Src, ALU_Op[1:0].
- rd1_in  in  DATA_W  read data 1.
- rd2_in  in  DATA_W  read data 2.
- imm_in  in  DATA_W  sign-extended immediate.
- rs_in  in  RADDR_W  Rs address.
- rt_in  in  RADDR_W  Rt address.
- rd_in  in  RADDR_W  Rd address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX accepts the head entry.
- ctrl_out  out  CTRL_W  head control word; all zeros whenever out_valid=0.
- rd1_out, rd2_out, imm_out  out  DATA_W  head payload.
- rs_out, rt_out, rd_out  out  RADDR_W  head addresses.
- occ  out  2  number of held entries (0..2).

Behaviour:
- Reset (reset_in=0, asynchronous):
  - out_valid=0, ctrl_out=0, occ=0.
  - Skid entry invalid; skid control cleared.
  - in_ready=1 after reset release.
  - Data and address registers are reset to 0.
- Transfers:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- in_ready:
  - SKID_EN=1: in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - SKID_EN=0: in_ready = !out_valid | out_ready.
- Latency: an accepted item appears on the outputs on the next clock edge when the stage is empty or draining.
- Head update:
  - If the head is empty or draining, the head loads the skid entry if it is valid, otherwise the accepted input.
  - If an accept occurs while the head is held (out_valid & !out_ready), the input goes into the skid entry.
  - Ordering is strictly FIFO.
- bubble_in:
  - The accepted entry is stored with ctrl=0, so it is still valid and occupies a slot; payload is don't-care.
  - A bubble is asserted only with in_valid=1; bubble_in with in_valid=0 is ignored.
- flush_in (synchronous, highest priority):
  - Next cycle: out_valid=0, skid invalid, ctrl_out=0, occ=0.
  - Any same-cycle accept is discarded.
  - A drain in the same cycle still counts for EX, because EX sampled the head before the edge.
- Empty head: when the head drains with no replacement, out_valid and ctrl are cleared to 0 on that edge.
- occ = out_valid + skid_valid; occ=2 implies in_ready=0.
- Simultaneous accept and drain with occ=1: the head takes the new item and occ stays 1.
- Simultaneous accept and drain with occ=2: not possible, since in_ready=0.
- Full to empty sequence: occ=2, then one drain gives 1 with in_ready=1 on the next cycle, then another drain gives 0.
- Reset asserted mid-transfer: contents are lost immediately and nothing is replayed.

Decomposition:
- pipe_pkg:
  - Control bit indices: CTRL_REGWRITE=0, MEMTOREG=1, MEMREAD=2, MEMWRITE=3, REGDST=4, ALUSRC=5, ALUOP=7:6.
  - CTRL_W, and the NOP control constant (all zeros).
- Sub-module pipe_skid_buf:
  - Generic payload width W, holds the valid/ready/skid logic, includes the flush input.
  - Instantiated once with the concatenated payload {ctrl, rd1, rd2, imm, rs, rt, rd}.
  - Bubble masking of ctrl is applied before entry.

Test Plan:
- Reset then single transfer: after reset_in rises, present ctrl=8'h31, rd1=32'h0000_0005, rs=5'd3 with out_ready=1.
  - Next cycle: out_valid=1, ctrl_out=8'h31, rd1_out=5, rs_out=3; the cycle after: out_valid=0, ctrl_out=0.
- Back-pressure: hold out_ready=0 and offer items A then B.
  - Expect occ=2 and in_ready=0 on the third cycle.
  - Release out_ready: A is seen, then B, with in_ready=1 one cycle after A drains.
- Load-use bubble: accept with bubble_in=1 and ctrl_in=8'hFF.
  - Expect out_valid=1, ctrl_out=8'h00, occ=1.
- Flush at occ=2 with in_valid=1 on the same cycle.
  - Next cycle: occ=0, out_valid=0, ctrl_out=0; the offered item never appears.
- Asynchronous reset mid-stream: drop reset_in between clock edges while occ=2.
  - Outputs clear immediately, with no clock edge needed.
- Streaming: 100 back-to-back transfers with out_ready=1 and random in_valid.
  - Output order equals input order, with no loss or duplication, for both SKID_EN=1 and SKID_EN=0.
